rpg_loader: RTL and testbench

//  Upstream feeder of the memory block's ROM-program port (rpg/rpg_addr/rpg_data/rpg_write).

---
 rtl/fgba_pkg.sv | 13 +
 rtl/rpg_word_pack.sv | 32 +++
 rtl/rpg_loader.sv | 145 ++++++++++++++
 tb/tb_rpg_loader.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/fgba_pkg.sv
// Shared constants for the pak-RAM program loader.
package fgba_pkg;
    localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;
    localparam int          RPG_ADDR_W    = 23;
    localparam logic [31:0] PAK_BASE      = 32'h0800_0000;
    localparam logic [31:0] MAX_WORDS_DEF = 32'h0080_0000;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_LEN      = 3'd1;
    localparam logic [2:0] ST_DATA     = 3'd2;
    localparam logic [2:0] ST_CHECKSUM = 3'd3;
    localparam logic [2:0] ST_FINISH   = 3'd4;
endpackage

// File: rtl/rpg_word_pack.sv
// Little-endian 4-lane byte assembler; o_valid marks the byte that
// completes a word, with the whole word presented combinationally.
module rpg_word_pack (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clear,
    input  logic        i_valid,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_valid
);
    logic [1:0]  r_lane;
    logic [23:0] r_bytes;

    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_lane  <= 2'd0;
            r_bytes <= 24'd0;
        end else if (i_valid) begin
            r_lane <= r_lane + 2'd1;
            unique case (r_lane)
                2'd0:    r_bytes[7:0]   <= i_byte;
                2'd1:    r_bytes[15:8]  <= i_byte;
                2'd2:    r_bytes[23:16] <= i_byte;
                default: ;
            endcase
        end
    end

    assign o_word  = {i_byte, r_bytes};
    assign o_valid = i_valid && (r_lane == 2'd3);
endmodule

// File: rtl/rpg_loader.sv
// UART byte stream -> pak RAM word loader driving the memory rpg port.
// Optional checksum trailer enabled by RPG_LOADER_CHECKSUM_EN.
module rpg_loader
    import fgba_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF,
    parameter int          ADDR_W    = RPG_ADDR_W,
    parameter logic [31:0] MAX_WORDS = MAX_WORDS_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rpg,
    output logic [ADDR_W-1:0] rpg_addr,
    output logic [31:0]       rpg_data,
    output logic              rpg_write,
    output logic              done,
    output logic              error
);
    logic [2:0]        r_state;
    logic              r_rpg;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_data;
    logic              r_write;
    logic              r_done;
    logic              r_error;
    logic [23:0]       r_left;
`ifdef RPG_LOADER_CHECKSUM_EN
    logic [31:0]       r_sum;
`endif

    logic        w_sync;
    logic        w_pk_in;
    logic [31:0] w_word;
    logic        w_word_vld;

    assign w_sync  = rx_valid && (rx_data == SYNC_BYTE) && (r_state == ST_IDLE);
    assign w_pk_in = rx_valid && ((r_state == ST_LEN)
                   || (r_state == ST_DATA && r_left != 24'd0)
                   || (r_state == ST_CHECKSUM));

    rpg_word_pack u_pack (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_sync),
        .i_valid (w_pk_in),
        .i_byte  (rx_data),
        .o_word  (w_word),
        .o_valid (w_word_vld)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_rpg   <= 1'b0;
            r_addr  <= '0;
            r_data  <= 32'd0;
            r_write <= 1'b0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_left  <= 24'd0;
`ifdef RPG_LOADER_CHECKSUM_EN
            r_sum   <= 32'd0;
`endif
        end else begin
            r_write <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_sync) begin
                        r_done  <= 1'b0;
                        r_error <= 1'b0;
                        r_state <= ST_LEN;
`ifdef RPG_LOADER_CHECKSUM_EN
                        r_sum   <= 32'd0;
`endif
                    end
                end
                ST_LEN: begin
                    if (w_word_vld) begin
                        if (w_word == 32'd0) begin
`ifdef RPG_LOADER_CHECKSUM_EN
                            r_left  <= 24'd0;
                            r_state <= ST_CHECKSUM;
`else
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
`endif
                        end else if (w_word > MAX_WORDS) begin
                            r_error <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_rpg   <= 1'b1;
                            r_addr  <= '0;
                            r_left  <= w_word[23:0];
                            r_state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    // the final address is held so a full-size load never wraps
                    if (r_write && r_left != 24'd0)
                        r_addr <= r_addr + 1'b1;
                    if (w_word_vld) begin
                        r_data  <= w_word;
                        r_write <= 1'b1;
                        r_left  <= r_left - 24'd1;
`ifdef RPG_LOADER_CHECKSUM_EN
                        r_sum   <= r_sum + w_word;
                        if (r_left == 24'd1)
                            r_state <= ST_CHECKSUM;
`endif
                    end
`ifndef RPG_LOADER_CHECKSUM_EN
                    else if (r_write && r_left == 24'd0)
                        r_state <= ST_FINISH;
`endif
                end
`ifdef RPG_LOADER_CHECKSUM_EN
                ST_CHECKSUM: begin
                    if (w_word_vld) begin
                        if (w_word != r_sum)
                            r_error <= 1'b1;
                        r_state <= ST_FINISH;
                    end
                end
`endif
                ST_FINISH: begin
                    r_rpg   <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rpg       = r_rpg;
    assign rpg_addr  = r_addr;
    assign rpg_data  = r_data;
    assign rpg_write = r_write;
    assign done      = r_done;
    assign error     = r_error;
endmodule

// File: tb/tb_rpg_loader.sv
// Randomised frame bench for rpg_loader with a queue-based reference model.
module tb_rpg_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rpg;
    logic [22:0] rpg_addr;
    logic [31:0] rpg_data;
    logic        rpg_write;
    logic        done;
    logic        error;

    localparam logic [31:0] MAXW = 32'h0080_0000;

    int checks = 0;
    int errors = 0;
    bit rpg_seen = 0;

    typedef struct {
        logic [22:0] a;
        logic [31:0] d;
    } wr_t;
    wr_t exp_q[$];
    wr_t e;

    always #5 clk = ~clk;

    rpg_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rpg       (rpg),
        .rpg_addr  (rpg_addr),
        .rpg_data  (rpg_data),
        .rpg_write (rpg_write),
        .done      (done),
        .error     (error)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rpg) rpg_seen = 1;
        if (rst_n && rpg_write) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 64'(rpg_addr), 64'(e.a));
                chk("wr_data", 64'(rpg_data), 64'(e.d));
            end
            chk("rpg_during_write", 64'(rpg), 64'd1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
        repeat (gap) tick();
    endtask

    function automatic int gapf(input bit b2b);
        return b2b ? 0 : int'($urandom_range(0, 2));
    endfunction

    task automatic send_word(input logic [31:0] w, input bit b2b);
        for (int i = 0; i < 4; i++) send(w[8*i +: 8], gapf(b2b));
    endtask

    task automatic frame(input logic [31:0] len, input logic [31:0] words[$],
                         input bit b2b, input bit bad_sum);
        logic [31:0] sum;
        bit ok;
        bit exp_err;
        sum = 32'd0;
        ok = (len != 0) && (len <= MAXW);
        exp_err = (len > MAXW);
        rpg_seen = 0;
        send(8'hA5, 0);
        chk("sync_clears_done", 64'(done), 64'd0);
        chk("sync_clears_error", 64'(error), 64'd0);
        send_word(len, b2b);
        if (ok) begin
            for (int i = 0; i < words.size(); i++) begin
                exp_q.push_back('{a: 23'(i), d: words[i]});
                sum = sum + words[i];
                send_word(words[i], b2b);
            end
        end
`ifdef RPG_LOADER_CHECKSUM_EN
        if (len <= MAXW) begin
            send_word(bad_sum ? sum + 32'd1 : sum, b2b);
            if (bad_sum) exp_err = 1;
        end
`else
        if (bad_sum) exp_err = exp_err;
`endif
        repeat (5) tick();
        chk("frame_done", 64'(done), 64'd1);
        chk("frame_error", 64'(error), 64'(exp_err));
        chk("frame_rpg_low", 64'(rpg), 64'd0);
        chk("writes_pending", 64'(exp_q.size()), 64'd0);
        if (!ok) chk("rpg_never_high", 64'(rpg_seen), 64'd0);
        exp_q.delete();
    endtask

    logic [31:0] wq[$];
    logic [31:0] empty_q[$];
    logic [31:0] w;
    logic [7:0]  nb;

    initial begin
        repeat (3) tick();
        chk("rst_rpg", 64'(rpg), 64'd0);
        chk("rst_write", 64'(rpg_write), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        chk("rst_addr", 64'(rpg_addr), 64'd0);
        chk("rst_data", 64'(rpg_data), 64'd0);
        rst_n = 1'b1;
        tick();

        wq = '{32'h4433_2211, 32'h8877_6655};
        frame(32'd2, wq, 0, 0);

        send(8'h00, 1);
        send(8'hFF, 1);
        chk("idle_ignores_bytes", 64'(rpg), 64'd0);
        frame(32'd0, empty_q, 0, 0);

        frame(32'h0080_0001, empty_q, 0, 0);

        send(8'hA5, 0);
        send_word(MAXW, 1);
        chk("max_len_accepted", 64'(rpg), 64'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;

        wq.delete();
        for (int i = 0; i < 3; i++) wq.push_back($urandom);
        frame(32'd3, wq, 1, 0);

        send(8'hA5, 0);
        send_word(32'd4, 0);
        w = $urandom;
        exp_q.push_back('{a: 23'd0, d: w});
        send_word(w, 0);
        w = $urandom;
        send(w[7:0], 0);
        send(w[15:8], 0);
        tick();
        chk("pre_reset_write_seen", 64'(exp_q.size()), 64'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_reset_rpg", 64'(rpg), 64'd0);
        chk("mid_reset_done", 64'(done), 64'd0);
        chk("mid_reset_error", 64'(error), 64'd0);
        exp_q.delete();
        wq.delete();
        for (int i = 0; i < 2; i++) wq.push_back($urandom);
        frame(32'd2, wq, 0, 0);

`ifdef RPG_LOADER_CHECKSUM_EN
        wq = '{32'd1, 32'd2};
        frame(32'd2, wq, 0, 0);
        frame(32'd2, wq, 0, 1);
`endif

        for (int f = 0; f < 8; f++) begin
            for (int n = 0; n < int'($urandom_range(0, 3)); n++) begin
                nb = 8'($urandom);
                if (nb == 8'hA5) nb = 8'h5A;
                send(nb, int'($urandom_range(0, 1)));
            end
            wq.delete();
            for (int i = 0; i < int'($urandom_range(1, 6)); i++) begin
                w = $urandom;
                if ($urandom_range(0, 3) == 0) w[15:8] = 8'hA5;
                wq.push_back(w);
            end
            frame(32'(wq.size()), wq, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
